// File: rtl/fpmult_arb_pkg.sv
// rtl/fpmult_arb_pkg.sv - shared types for the fpmult arbiter slice
package fpmult_arb_pkg;

    typedef logic [31:0] fp32_t;

    localparam int NREQ_MAX = 8;
    localparam int IDW_MAX  = $clog2(NREQ_MAX);

    typedef struct packed {
        logic               valid;
        fp32_t              a;
        fp32_t              b;
        logic [IDW_MAX-1:0] id;
    } stage_t;

endpackage

// File: rtl/fpmult.sv
// rtl/fpmult.sv - combinational binary32 multiplier, RNE, subnormals flushed to zero
module fpmult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] m
);

    logic              sign;
    logic [7:0]        ea, eb;
    logic [23:0]       ma, mb;
    logic [47:0]       p;
    logic [22:0]       frac;
    logic [23:0]       frac_r;
    logic              guard, sticky, rnd;
    logic signed [9:0] e;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign ma     = {1'b1, a[22:0]};
    assign mb     = {1'b1, b[22:0]};
    assign p      = {24'b0, ma} * {24'b0, mb};
    assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'b0);
    assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'b0);
    assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'b0);
    assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'b0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    always_comb begin
        m      = '0;
        frac   = p[45:23];
        guard  = p[22];
        sticky = |p[21:0];
        e      = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127;
        if (p[47]) begin
            frac   = p[46:24];
            guard  = p[23];
            sticky = |p[22:0];
            e      = e + 10'sd1;
        end
        rnd    = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {23'b0, rnd};
        // Rounding carry out of the fraction bumps the exponent; fraction is already zero.
        if (frac_r[23]) begin
            e = e + 10'sd1;
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            m = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
            m = {sign, 8'hFF, 23'b0};
        end else if (a_zero || b_zero) begin
            m = {sign, 31'b0};
        end else if (e >= 10'sd255) begin
            m = {sign, 8'hFF, 23'b0};
        end else if (e <= 10'sd0) begin
            m = {sign, 31'b0};
        end else begin
            m = {sign, e[7:0], frac_r[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, first requester at or after ptr wins
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic found;
    int   k;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = PW'(k);
            end
        end
    end

endmodule

// File: rtl/fpmult_arbiter.sv
// rtl/fpmult_arbiter.sv - round-robin sharing of one fpmult among NREQ requesters
module fpmult_arbiter
    import fpmult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [31:0]        rsp_data,
    output logic               busy
);

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] req_eff;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    stage_t          s1;
    logic            s2_valid;
    logic [IDW-1:0]  s2_id;
    fp32_t           s2_m;
    fp32_t           prod;
    logic            unused_id;

    assign req_eff = (reset || hold) ? '0 : req_valid;

    rr_arbiter #(
        .N  (NREQ),
        .PW (IDW)
    ) u_rr (
        .req       (req_eff),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    fpmult u_fpmult (
        .a (s1.a),
        .b (s1.b),
        .m (prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            s1       <= '0;
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_m     <= '0;
        end else begin
            if (|grant) begin
                rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                s1.valid <= 1'b1;
                s1.a     <= req_a[32*grant_idx +: 32];
                s1.b     <= req_b[32*grant_idx +: 32];
                s1.id    <= IDW_MAX'(grant_idx);
            end else begin
                s1.valid <= 1'b0;
            end
            s2_valid <= s1.valid;
            // Result registers only load on a valid op so rsp_id/rsp_data hold between pulses.
            if (s1.valid) begin
                s2_id <= s1.id[IDW-1:0];
                s2_m  <= prod;
            end
        end
    end

    assign unused_id = ^s1.id;

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_data  = s2_m;
    assign busy      = s1.valid | s2_valid;

endmodule

// File: tb/tb_fpmult_arbiter.sv
// tb/tb_fpmult_arbiter.sv - table-driven bench with response scoreboard for fpmult_arbiter
module tb_fpmult_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         hold;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         busy;

    always #5 clk = ~clk;

    fpmult_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    typedef struct {
        logic       rst;
        logic       hld;
        logic [3:0] vld;
        logic [3:0] rdy;
        int         ops;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] m;
        int          due;
    } exp_t;

    vec_t        vq[$];
    exp_t        sb[$];
    logic [31:0] op_a[3][4];
    logic [31:0] op_b[3][4];
    logic [31:0] op_m[3][4];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cur_k   = 0;
    logic [31:0] last_m  = 32'h0;
    logic [1:0]  last_id = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h expected %h", name, cur_k, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic h, input logic [3:0] v,
                       input logic [3:0] e, input int o);
        vec_t x;
        x.rst = r; x.hld = h; x.vld = v; x.rdy = e; x.ops = o;
        vq.push_back(x);
    endtask

    function automatic int oh2i(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        exp_t e;
        logic exp_busy;

        for (int s = 0; s < 3; s++) begin
            op_a[s] = '{32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000};
            op_b[s] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
            op_m[s] = '{32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000};
        end
        op_a[1][2] = 32'h3F75_0000; op_b[1][2] = 32'h3FC0_0000; op_m[1][2] = 32'h3FB7_C000;
        op_a[2][0] = 32'h3F80_0000; op_b[2][0] = 32'hBF80_0000; op_m[2][0] = 32'hBF80_0000;

        // reset with all valid, then 8 rotating grants
        repeat (3) add(1, 0, 4'hF, 4'h0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 4'hF, 4'(1 << (i % 4)), 0);
        repeat (3) add(0, 0, 4'h0, 4'h0, 0);
        // requester 2 alone
        add(0, 0, 4'h4, 4'h4, 1);
        repeat (3) add(0, 0, 4'h0, 4'h0, 1);
        // hold one cycle after a grant, then resume from rr_ptr
        add(0, 0, 4'h1, 4'h1, 2);
        repeat (3) add(0, 1, 4'hF, 4'h0, 2);
        add(0, 0, 4'hF, 4'h2, 2);
        add(0, 0, 4'h0, 4'h0, 2);
        // reset while both stages are full
        add(0, 0, 4'hF, 4'h4, 0);
        add(0, 0, 4'hF, 4'h8, 0);
        add(1, 0, 4'hF, 4'h0, 0);
        add(0, 0, 4'hA, 4'h2, 0);
        repeat (3) add(0, 0, 4'h0, 4'h0, 0);
        // requester 1 withdraws while 0 is granted
        add(0, 0, 4'h8, 4'h8, 0);
        add(0, 0, 4'h3, 4'h1, 0);
        add(0, 0, 4'h4, 4'h4, 0);
        repeat (3) add(0, 0, 4'h0, 4'h0, 0);

        reset = 1'b1; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < vq.size(); k++) begin
            cur_k     = k;
            reset     = vq[k].rst;
            hold      = vq[k].hld;
            req_valid = vq[k].vld;
            for (int i = 0; i < 4; i++) begin
                req_a[32*i +: 32] = op_a[vq[k].ops][i];
                req_b[32*i +: 32] = op_b[vq[k].ops][i];
            end
            @(negedge clk);

            if (k == 0) begin
                chk("reset_rsp_id", {30'b0, rsp_id}, 32'h0);
                chk("reset_rsp_data", rsp_data, 32'h0);
            end

            if (sb.size() > 0 && sb[0].due == k) begin
                e = sb.pop_front();
                chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
                chk("rsp_id", {30'b0, rsp_id}, {30'b0, e.id});
                chk("rsp_data", rsp_data, e.m);
                last_m  = e.m;
                last_id = e.id;
            end else begin
                chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'h0);
                chk("rsp_data_hold", rsp_data, last_m);
                chk("rsp_id_hold", {30'b0, rsp_id}, {30'b0, last_id});
            end

            chk("req_ready", {28'b0, req_ready}, {28'b0, vq[k].rdy});
            if (vq[k].rdy != 4'h0) begin
                e.id  = 2'(oh2i(vq[k].rdy));
                e.m   = op_m[vq[k].ops][oh2i(vq[k].rdy)];
                e.due = k + 2;
                sb.push_back(e);
            end

            exp_busy = (k >= 1 && vq[k-1].rdy != 4'h0) ||
                       (k >= 2 && vq[k-2].rdy != 4'h0 && !vq[k-1].rst);
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});

            if (vq[k].rst) begin
                sb.delete();
                last_m  = 32'h0;
                last_id = 2'd0;
            end

            @(posedge clk);
            #1;
        end

        cur_k = vq.size();
        chk("scoreboard_empty", sb.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpmult_arbiter.md
Name: fpmult_arbiter

Overview:
Shares one combinational single-precision multiplier (fpmult: a, b -> m, IEEE-754 binary32) among NREQ requesters.
- Round-robin arbitration grants one request per cycle.
- Operands are registered into an issue stage, fpmult evaluates between the issue and result registers, and the product returns tagged with the requester ID.
- Sits between the core's FP issue logic and the shared fpmult instance; the fpmult datapath is owned by this block.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of the requester ID tag

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
hold  input  1  1 = issue no new grants; in-flight operations still drain
req_valid  input  NREQ  per-requester request valid
req_a  input  NREQ*32  operand A per requester; slice i = [32*i+31:32*i]
req_b  input  NREQ*32  operand B per requester, same packing
req_ready  output  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
rsp_valid  output  1  result valid, one-cycle pulse
rsp_id  output  IDW  requester index of the result
rsp_data  output  32  product a*b from fpmult
busy  output  1  1 while any pipeline stage holds a valid operation

Behaviour:
Reset (synchronous; takes effect on the clk edge where reset=1):
- rr_ptr=0, s1_valid=0, s2_valid=0.
- rsp_valid=0, rsp_id=0, rsp_data=32'h0, busy=0.
- req_ready=0 while reset is asserted.
- Reset mid-operation discards in-flight ops; no response is produced for them.

Arbitration (combinational from req_valid, rr_ptr, hold, reset):
- Scan indices rr_ptr, rr_ptr+1, ... mod NREQ; grant the first with req_valid=1.
- req_ready is one-hot or zero. It is zero when hold=1 or when no request is pending.
- On a grant to index g, rr_ptr <= (g+1) mod NREQ at the clock edge; otherwise rr_ptr holds.
- Requesters hold req_valid and operands stable until granted; the arbiter samples operands only on the grant cycle.

Pipeline (no response backpressure; the consumer must accept every rsp_valid pulse):
- Cycle t, grant: s1 <= {a, b, id = g}; s1_valid <= 1. With no grant, s1_valid <= 0.
- Cycle t+1: fpmult(s1_a, s1_b) is evaluated; s2 <= {m, s1_id}; s2_valid <= s1_valid.
- rsp_valid = s2_valid, rsp_id = s2_id, rsp_data = s2_m. Fixed latency of 2 cycles from the grant edge to rsp_valid.
- rsp_data and rsp_id hold their last value when rsp_valid=0.
- Full throughput: one grant per cycle, back to back.
- busy = s1_valid | s2_valid.

Boundary cases:
- All NREQ requesters valid continuously: grants rotate 0,1,...,NREQ-1,0,... Each requester waits at most NREQ-1 cycles.
- Single requester valid continuously: it is granted every cycle.
- hold asserted while s1/s2 are valid: both stages drain normally. hold deasserted: arbitration resumes from the current rr_ptr.
- Requester drops req_valid before being granted: this is legal. It is simply not granted.
- The multiplier's NaN/Inf/denormal handling belongs to fpmult. The arbiter passes bits through unmodified.

Decomposition:
- Package fpmult_arb_pkg holds:
  - typedef fp32_t (logic [31:0]);
  - NREQ_MAX=8;
  - typedef of the pipeline stage struct {valid, a, b, id}.
- Sub-module rr_arbiter (params N): inputs req, ptr; outputs grant (one-hot) and grant_idx. Reused elsewhere for other shared units.
- fpmult is instantiated once inside the top level, unmodified.

Test Plan:
1. Reset held 3 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0. After release, first grant goes to requester 0.
2. Requester 2 alone: a=32'h3F75_0000, b=32'h3FC0_0000. Expect req_ready=4'b0100 at cycle t; at t+2, rsp_valid=1, rsp_id=2, rsp_data=32'h3FB7_C000.
3. All four requesters valid for 8 cycles with distinct operands. Requester i uses a=32'h4000_0000 (2.0) and b of value i+1, i.e. 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000. Expect:
   - grant order 0,1,2,3,0,1,2,3;
   - rsp_id stream identical to the grant order, delayed 2 cycles;
   - rsp_data 32'h4000_0000, 32'h4080_0000, 32'h40C0_0000, 32'h4100_0000 repeating.
4. hold=1 asserted one cycle after a grant of 32'h3F80_0000 * 32'hBF80_0000 -> no new req_ready while hold=1; pending result still emerges with rsp_data=32'hBF80_0000; busy falls to 0 once drained.
5. reset pulsed for one cycle while s1_valid=1 and s2_valid=1 -> rsp_valid=0 on following cycles (both ops dropped); rr_ptr=0, so the next grant goes to the lowest valid index.
6. Requester 1 lowers req_valid while requester 0 is being granted -> requester 1 never receives req_ready; rr_ptr advances to 1; the next grant goes to the next valid index after 0.
